// File: rtl/regfile_dump_if.sv
// Output stream of the register-file dump engine: one (index, value) word per transfer.
// A word moves on every rising edge where out_valid && out_ready; the master holds it stable until then.
interface regfile_dump_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug readout engine: walks regfile read port 1 from FIRST_REG to x31 and streams
// each (index, value) word out; done pulses once after the last word or an abort.
module regfile_dump #(
    parameter int FIRST_REG = 1,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_a,
    input  logic [DATA_W-1:0] rf_rd,
    output logic [1:0]        dbg_state,
    regfile_dump_if.master    dump
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'd31;

    state_t     state;
    logic [4:0] idx;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 5'd0;
            rf_a           <= 5'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dump.out_valid <= 1'b0;
            dump.out_addr  <= 5'd0;
            dump.out_data  <= '0;
            dump.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= FIRST;
                        rf_a  <= FIRST;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Regfile read is combinational, so this edge is the snapshot point for idx.
                        dump.out_data  <= rf_rd;
                        dump.out_addr  <= idx;
                        dump.out_last  <= (idx == LAST);
                        dump.out_valid <= 1'b1;
                        state          <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Abort wins over a coincident handshake; that word is treated as undelivered.
                    if (abort) begin
                        dump.out_valid <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end else if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                        if (idx == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            rf_a  <= idx + 5'd1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rf_a  <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural regfile feeds two instances
// (FIRST_REG = 1 and FIRST_REG = 0); delivered words are captured into queues.
module tb_regfile_dump;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start1, abort1, start0, abort0;
    logic        busy1, done1, busy0, done0;
    logic [4:0]  rf_a1, rf_a0;
    logic [31:0] rf_rd1, rf_rd0;
    logic [1:0]  st1, st0;
    logic [31:0] rf [32];

    regfile_dump_if #(.DATA_W(32)) if1 ();
    regfile_dump_if #(.DATA_W(32)) if0 ();

    // x0 reads as zero regardless of what was written to it.
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : rf[rf_a1];
    assign rf_rd0 = (rf_a0 == 5'd0) ? 32'd0 : rf[rf_a0];

    regfile_dump #(.FIRST_REG(1), .DATA_W(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .rf_a(rf_a1), .rf_rd(rf_rd1),
        .dbg_state(st1), .dump(if1.master)
    );

    regfile_dump #(.FIRST_REG(0), .DATA_W(32)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .rf_a(rf_a0), .rf_rd(rf_rd0),
        .dbg_state(st0), .dump(if0.master)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word = {last, addr, data}
    logic [37:0] got1_q[$];
    logic [37:0] got0_q[$];
    logic [37:0] exp_q[$];
    int done_cnt1 = 0;
    int done_cnt0 = 0;
    int n_pass = 0;
    int n_total = 0;

    always @(negedge clk) begin
        if (!reset && if1.out_valid && if1.out_ready && !abort1)
            got1_q.push_back({if1.out_last, if1.out_addr, if1.out_data});
        if (!reset && if0.out_valid && if0.out_ready && !abort0)
            got0_q.push_back({if0.out_last, if0.out_addr, if0.out_data});
        if (!reset && done1) done_cnt1++;
        if (!reset && done0) done_cnt0++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word1(input logic [4:0] a);
        int k = 0;
        while (!(if1.out_valid && if1.out_addr == a) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("wait_word", {if1.out_valid, if1.out_addr}, {1'b1, a});
    endtask

    task automatic wait_done(input bit which, output int at);
        int k = 0;
        while (!(which ? done1 : done0) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("wait_done", which ? done1 : done0, 1'b1);
        at = cyc;
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_busy"}, busy1, 1'b0);
        check({tag, "_done"}, done1, 1'b0);
        check({tag, "_rf_a"}, rf_a1, 5'd0);
        check({tag, "_valid"}, if1.out_valid, 1'b0);
        check({tag, "_addr"}, if1.out_addr, 5'd0);
        check({tag, "_data"}, if1.out_data, 32'd0);
        check({tag, "_last"}, if1.out_last, 1'b0);
        check({tag, "_state"}, st1, 2'd0);
    endtask

    initial begin
        int t0, td, seq_ok;
        logic [37:0] w;

        reset = 1'b1; start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        if1.out_ready = 1'b0; if0.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        rf[1] = 32'd42;
        rf[5] = 32'hDEADBEEF;

        // Reset values
        tick(); tick();
        check_idle1("reset");
        check("reset_busy0", busy0, 1'b0);
        reset = 1'b0;
        tick();

        // Full readout, default parameters, no backpressure
        got1_q.delete(); done_cnt1 = 0;
        if1.out_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0; t0 = cyc;
        check("start_busy", busy1, 1'b1);
        check("start_state", st1, 2'd1);
        check("start_rf_a", rf_a1, 5'd1);
        check("start_valid", if1.out_valid, 1'b0);
        tick();
        check("first_valid", if1.out_valid, 1'b1);
        check("first_word", {if1.out_last, if1.out_addr, if1.out_data}, {1'b0, 5'd1, 32'd42});
        wait_done(1'b1, td);
        check("full_done_time", td - t0, 62);
        tick();
        check("full_done_pulse", done1, 1'b0);
        check("full_busy_fall", busy1, 1'b0);
        check("full_done_count", done_cnt1, 1);
        exp_q.delete();
        for (int i = 1; i < 32; i++)
            exp_q.push_back({i == 31, 5'(i), (i == 1) ? 32'd42 : (i == 5) ? 32'hDEADBEEF : 32'(i * 3)});
        check("full_count", got1_q.size(), 31);
        for (int k = 0; k < exp_q.size(); k++) begin
            w = (k < got1_q.size()) ? got1_q[k] : 'x;
            check($sformatf("full_word_%0d", k + 1), w, exp_q[k]);
        end

        // x0 write guard with FIRST_REG = 0
        rf[0] = 32'd99;
        got0_q.delete(); done_cnt0 = 0;
        if0.out_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0; t0 = cyc;
        wait_done(1'b0, td);
        tick();
        check("x0_count", got0_q.size(), 32);
        check("x0_first", got0_q[0], {1'b0, 5'd0, 32'd0});
        check("x0_word5", got0_q[5], {1'b0, 5'd5, 32'hDEADBEEF});
        check("x0_last", got0_q[31], {1'b1, 5'd31, 32'd93});
        check("x0_done_time", td - t0, 64);
        check("x0_done_count", done_cnt0, 1);

        // Backpressure: stall addr 3 for 7 cycles
        got1_q.delete();
        start1 = 1'b1; tick(); start1 = 1'b0; t0 = cyc;
        wait_word1(5'd3);
        if1.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("stall_word", {if1.out_valid, if1.out_addr, if1.out_data}, {1'b1, 5'd3, 32'd9});
        end
        if1.out_ready = 1'b1;
        wait_done(1'b1, td);
        check("stall_done_time", td - t0, 69);
        tick();
        check("stall_count", got1_q.size(), 31);
        seq_ok = 0;
        foreach (got1_q[k]) if (got1_q[k][36:32] == 5'(k + 1)) seq_ok++;
        check("stall_sequence", seq_ok, 31);

        // Abort together with a handshake on addr 10
        got1_q.delete(); done_cnt1 = 0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_word1(5'd10);
        abort1 = 1'b1; tick(); abort1 = 1'b0;
        check("abort_state", st1, 2'd3);
        check("abort_done", done1, 1'b1);
        check("abort_valid", if1.out_valid, 1'b0);
        check("abort_count", got1_q.size(), 9);
        check("abort_last_addr", got1_q[got1_q.size() - 1][36:32], 5'd9);
        tick();
        check("abort_idle_state", st1, 2'd0);
        check("abort_idle_busy", busy1, 1'b0);
        check("abort_done_count", done_cnt1, 1);

        // Restart, ignored start while addr 4 pending
        got1_q.delete(); done_cnt1 = 0;
        start1 = 1'b1; tick(); start1 = 1'b0; tick();
        check("restart_word", {if1.out_valid, if1.out_addr}, {1'b1, 5'd1});
        wait_word1(5'd4);
        if1.out_ready = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("busy_start_word", {if1.out_valid, if1.out_addr, if1.out_data}, {1'b1, 5'd4, 32'd12});
        check("busy_start_state", st1, 2'd2);
        if1.out_ready = 1'b1;
        tick(); tick();
        check("after_start_word", {if1.out_valid, if1.out_addr}, {1'b1, 5'd5});
        check("after_start_count", got1_q.size(), 4);
        check("after_start_last", got1_q[got1_q.size() - 1][36:32], 5'd4);

        // Reset during addr 12
        wait_word1(5'd12);
        reset = 1'b1; tick(); reset = 1'b0;
        check_idle1("midreset");
        for (int k = 0; k < 10; k++) tick();
        check("midreset_no_done", done_cnt1, 0);
        check("midreset_still_idle", {busy1, st1}, 3'd0);

        // Concurrent write while addr 8 is presented
        got1_q.delete();
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_word1(5'd8);
        rf[20] = 32'd7;
        rf[2] = 32'd7;
        wait_done(1'b1, td);
        tick();
        check("cw_count", got1_q.size(), 31);
        check("cw_x2_old", got1_q[1], {1'b0, 5'd2, 32'd6});
        check("cw_x20_new", got1_q[19], {1'b0, 5'd20, 32'd7});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
